// File: rtl/vdiv_32by16_pkg.sv
// Shared definitions for the 32/16 restoring divider: FSM encoding and
// full-adder helpers used to build the subtract chain.
package vdiv_32by16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

endpackage

// File: rtl/vdiv_32by16_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor through a full-adder chain, keep or restore.
module div_step
   import vdiv_32by16_pkg::*;
#(
   parameter int VW = 16
) (
   input  logic [VW-1:0] p,
   input  logic          msb_in,
   input  logic [VW-1:0] b,
   output logic [VW-1:0] p_next,
   output logic          qbit
);

   logic [VW:0]   t_s;
   logic [VW-1:0] diff_s;
   logic          cy_s;

   assign t_s = {p, msb_in};

   // t - {0,b} as t + ~{0,b} + 1; carry out of the top stage means no borrow (t >= b).
   // The top difference bit is always zero when kept, so only its carry is formed.
   always_comb begin
      cy_s   = 1'b1;
      diff_s = '0;
      for (int i = 0; i < VW; i++) begin
         diff_s[i] = fa_sum(t_s[i], ~b[i], cy_s);
         cy_s      = fa_carry(t_s[i], ~b[i], cy_s);
      end
      qbit = fa_carry(t_s[VW], 1'b1, cy_s);
      if (qbit) begin
         p_next = diff_s;
      end else begin
         p_next = t_s[VW-1:0];
      end
   end

endmodule

// File: rtl/vdiv_32by16.sv
// Sequential restoring divider, DW-bit dividend by VW-bit divisor, one
// quotient bit per clock; results are held until the next accepted start.
module vdiv_32by16
   import vdiv_32by16_pkg::*;
#(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] a,
   input  logic [VW-1:0] b,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] q,
   output logic [VW-1:0] r,
   output logic          dz
);

   localparam int            CW   = $clog2(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r;
   logic [VW-1:0] p_r, b_r, p_next_s, r_r;
   logic [DW-1:0] s_r, s_shift_s, q_r;
   logic          dz_r, qbit_s, accept_s;

   div_step #(.VW(VW)) u_step (
      .p      (p_r),
      .msb_in (s_r[DW-1]),
      .b      (b_r),
      .p_next (p_next_s),
      .qbit   (qbit_s)
   );

   assign s_shift_s = {s_r[DW-2:0], qbit_s};
   assign accept_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

   // Next-state logic; a zero divisor still passes through RUN for one cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == LAST) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture, iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         p_r   <= '0;
         s_r   <= '0;
         b_r   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         dz_r  <= 1'b0;
      end else if (accept_s) begin
         s_r   <= a;
         b_r   <= b;
         p_r   <= '0;
         // Zero divisor jumps straight to the last iteration so it completes next edge.
         cnt_r <= (b == '0) ? LAST : '0;
      end else if (state_r == ST_RUN) begin
         if (b_r == '0) begin
            q_r  <= {DW{1'b1}};
            r_r  <= s_r[VW-1:0];
            dz_r <= 1'b1;
         end else begin
            p_r <= p_next_s;
            s_r <= s_shift_s;
            if (cnt_r == LAST) begin
               q_r  <= s_shift_s;
               r_r  <= p_next_s;
               dz_r <= 1'b0;
            end else begin
               cnt_r <= cnt_r + CW'(1);
            end
         end
      end
   end

   assign busy = (state_r == ST_RUN);
   assign done = (state_r == ST_DONE);
   assign q    = q_r;
   assign r    = r_r;
   assign dz   = dz_r;

endmodule

// File: tb/tb_vdiv_32by16.sv
// Self-checking bench for vdiv_32by16: directed cases plus randomized
// divisions checked every cycle against a plain-arithmetic reference.
module tb_vdiv_32by16;

   localparam int DW = 32;
   localparam int VW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start;
   logic [DW-1:0] a;
   logic [VW-1:0] b;
   logic          busy, done, dz;
   logic [DW-1:0] q;
   logic [VW-1:0] r;

   vdiv_32by16 #(.DW(DW), .VW(VW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .r     (r),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_d = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          d;
      logic [31:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;

   exp_t        pend[$];
   logic [31:0] held_q  = 32'h0;
   logic [15:0] held_r  = 16'h0;
   logic        held_dz = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] aa, input logic [15:0] bb);
      exp_t e;
      e.d = 0;
      if (bb == 16'h0) begin
         e.q  = 32'hFFFF_FFFF;
         e.r  = aa[15:0];
         e.dz = 1'b1;
      end else begin
         e.q  = aa / {16'h0, bb};
         e.r  = 16'(aa % {16'h0, bb});
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Cycle-by-cycle compare of handshake and held results.
   always @(negedge clk) begin : compare
      logic exp_done, exp_busy;
      exp_done = (pend.size() > 0) && (cyc == pend[0].d);
      exp_busy = (pend.size() > 0) && (cyc < pend[0].d);
      if (exp_done) begin
         held_q  = pend[0].q;
         held_r  = pend[0].r;
         held_dz = pend[0].dz;
         void'(pend.pop_front());
      end
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      chk("q", q, held_q);
      chk("r", r, held_r);
      chk("dz", dz, held_dz);
   end

   task automatic go(input logic [31:0] aa, input logic [15:0] bb,
                     input logic [31:0] eq, input logic [15:0] er, input logic edz);
      exp_t e;
      start = 1'b1;
      a     = aa;
      b     = bb;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = 16'($urandom);
      e.d   = cyc + ((bb == 16'h0) ? 1 : DW);
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      pend.push_back(e);
      last_d = e.d;
   endtask

   task automatic wait_to(input int d);
      while (cyc < d) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      exp_t em;
      int   k;
      logic [31:0] aa;
      logic [15:0] bb;
      longint lim;

      start = 1'b0;
      a     = 32'h0;
      b     = 16'h0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q", q, 32'h0);
      chk("rst_r", r, 16'h0);
      chk("rst_dz", dz, 1'b0);
      gap(2);
      rst_n = 1'b1;
      gap(1);

      em = model(32'd100, 16'd7);
      chk("model_q_100_7", em.q, 32'd14);
      chk("model_r_100_7", em.r, 16'd2);
      em = model(32'd1234, 16'd0);
      chk("model_q_div0", em.q, 32'hFFFF_FFFF);
      chk("model_r_div0", em.r, 16'h04D2);
      chk("model_dz_div0", em.dz, 1'b1);

      go(32'd100, 16'd7, 32'd14, 16'd2, 1'b0);
      wait_to(last_d);
      chk("lat_100_7_done", done, 1'b1);
      chk("q_100_7", q, 32'd14);
      go(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0);
      wait_to(last_d);
      gap(1);
      go(32'h0000_0005, 16'h0009, 32'h0, 16'd5, 1'b0);
      wait_to(last_d);
      gap(2);
      go(32'd1234, 16'h0, 32'hFFFF_FFFF, 16'h04D2, 1'b1);
      wait_to(last_d);
      chk("lat_div0_done", done, 1'b1);
      go(32'd10, 16'd3, 32'd3, 16'd1, 1'b0);
      wait_to(last_d);
      gap(1);

      // Start pulsed mid-run must not disturb the running division.
      go(32'd100, 16'd7, 32'd14, 16'd2, 1'b0);
      k = last_d - DW;
      wait_to(k + 10);
      start = 1'b1;
      a     = 32'd5;
      b     = 16'd9;
      gap(1);
      start = 1'b0;
      wait_to(last_d);
      gap(1);

      // Reset mid-run: immediate clear, no done afterwards.
      em = model(32'h1234_5678, 16'h0123);
      go(32'h1234_5678, 16'h0123, em.q, em.r, em.dz);
      k = last_d - DW;
      wait_to(k + 15);
      rst_n = 1'b0;
      pend.delete();
      held_q  = 32'h0;
      held_r  = 16'h0;
      held_dz = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_q", q, 32'h0);
      chk("midrst_r", r, 16'h0);
      chk("midrst_dz", dz, 1'b0);
      gap(2);
      rst_n = 1'b1;
      gap(DW + 2);
      go(32'd10, 16'd3, 32'd3, 16'd1, 1'b0);
      wait_to(last_d);
      gap(1);

      for (int i = 0; i < 1000; i++) begin
         bb  = 16'($urandom_range(65535, 1));
         lim = longint'(bb) << 16;
         aa  = 32'(longint'($urandom) % lim);
         em  = model(aa, bb);
         go(aa, bb, em.q, em.r, em.dz);
         wait_to(last_d);
         chk("inv_mul", 64'(longint'(q[15:0]) * longint'(bb) + longint'(r)), 64'(aa));
         chk("inv_r_lt_b", (r < bb), 1'b1);
         chk("inv_q_hi", q[31:16], 16'h0);
         if ($urandom_range(1, 0) == 1) begin
            gap($urandom_range(3, 1));
         end
      end

      gap(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
